// File: rtl/mem32k_word_ctrl_if.sv
// Request/response bundle between the SHA-256 datapath and mem32k_word_ctrl.
//   REQ_VALID/REQ_READY : request handshake (accept when both high at CLK rise)
//   REQ_WE              : 1 = write word, 0 = read word
//   REQ_ADDR            : 13-bit word address
//   REQ_WDATA           : write word, bits [31:24] land at byte offset 0
//   RSP_VALID           : one-cycle completion pulse (write ack or read data)
//   RSP_RDATA           : last read word, held until the next read completes
interface mem32k_word_ctrl_if;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic        REQ_WE;
  logic [12:0] REQ_ADDR;
  logic [31:0] REQ_WDATA;
  logic        RSP_VALID;
  logic [31:0] RSP_RDATA;

  modport master (
    output REQ_VALID, REQ_WE, REQ_ADDR, REQ_WDATA,
    input  REQ_READY, RSP_VALID, RSP_RDATA
  );

  modport slave (
    input  REQ_VALID, REQ_WE, REQ_ADDR, REQ_WDATA,
    output REQ_READY, RSP_VALID, RSP_RDATA
  );
endinterface

// File: rtl/mem32k_word_ctrl.sv
// Word-access controller in front of a 32K x 8 asynchronous SRAM.
// Splits each 32-bit request into four big-endian byte cycles and drives the
// SRAM's active-low CS/OE/WE strobes with setup, strobe and hold phases.
//   CLK, RST : clock, asynchronous active-high reset
//   bus      : request/response handshake (mem32k_word_ctrl_if.slave)
//   A        : SRAM byte address {word address, byte index}
//   IO       : SRAM data bus, driven only in write phases
//   CS/OE/WE : SRAM strobes, active low
// STROBE_CYC sets the WE pulse / read wait length in cycles (1..15).
module mem32k_word_ctrl #(
  parameter int unsigned STROBE_CYC = 2
) (
  input  logic                CLK,
  input  logic                RST,
  mem32k_word_ctrl_if.slave   bus,
  output logic [14:0]         A,
  inout  wire  [7:0]          IO,
  output logic                CS,
  output logic                OE,
  output logic                WE
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_W_SETUP,
    S_W_PULSE,
    S_W_HOLD,
    S_R_SETUP,
    S_R_WAIT,
    S_TURN
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(STROBE_CYC - 1);

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [12:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rbuf_q, rbuf_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        ready_q, ready_d;
  logic        cs_q, cs_d;
  logic        oe_q, oe_d;
  logic        we_q, we_d;
  logic [14:0] a_q, a_d;
  logic        io_oe_q, io_oe_d;
  logic [7:0]  io_out_q, io_out_d;
  logic        strobe_last;

  // Next-state logic. Pin-side outputs are derived from the next state and
  // registered, so SRAM pins change only at clock edges and never follow
  // REQ_* combinationally.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rbuf_d      = rbuf_q;
    rdata_d     = rdata_q;
    strobe_last = (cnt_q == CNT_LAST);

    unique case (state_q)
      S_IDLE: begin
        if (bus.REQ_VALID && ready_q) begin
          addr_d  = bus.REQ_ADDR;
          wdata_d = bus.REQ_WDATA;
          idx_d   = '0;
          state_d = bus.REQ_WE ? S_W_SETUP : S_R_SETUP;
        end
      end
      S_W_SETUP: begin
        cnt_d   = '0;
        state_d = S_W_PULSE;
      end
      S_W_PULSE: begin
        if (strobe_last) state_d = S_W_HOLD;
        else             cnt_d   = cnt_q + 4'd1;
      end
      S_W_HOLD: begin
        if (idx_q == 2'd3) begin
          state_d = S_TURN;
        end else begin
          idx_d   = idx_q + 2'd1;
          state_d = S_W_SETUP;
        end
      end
      S_R_SETUP: begin
        cnt_d   = '0;
        state_d = S_R_WAIT;
      end
      S_R_WAIT: begin
        if (strobe_last) begin
          unique case (idx_q)
            2'd0: rbuf_d[31:24] = IO;
            2'd1: rbuf_d[23:16] = IO;
            2'd2: rbuf_d[15:8]  = IO;
            2'd3: rbuf_d[7:0]   = IO;
          endcase
          if (idx_q == 2'd3) begin
            // Last byte goes straight into the response word on the same
            // edge that enters TURN.
            rdata_d = rbuf_d;
            state_d = S_TURN;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = S_R_SETUP;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_TURN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    cs_d        = !(state_d inside {S_W_SETUP, S_W_PULSE, S_W_HOLD, S_R_SETUP, S_R_WAIT});
    oe_d        = !(state_d inside {S_R_SETUP, S_R_WAIT});
    we_d        = !(state_d == S_W_PULSE);
    io_oe_d     = state_d inside {S_W_SETUP, S_W_PULSE, S_W_HOLD};
    rsp_valid_d = (state_d == S_TURN);
    ready_d     = (state_d == S_IDLE);
    a_d         = {addr_d, idx_d};

    unique case (idx_d)
      2'd0: io_out_d = wdata_d[31:24];
      2'd1: io_out_d = wdata_d[23:16];
      2'd2: io_out_d = wdata_d[15:8];
      2'd3: io_out_d = wdata_d[7:0];
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rbuf_q      <= '0;
      rdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      ready_q     <= 1'b0;
      cs_q        <= 1'b1;
      oe_q        <= 1'b1;
      we_q        <= 1'b1;
      a_q         <= '0;
      io_oe_q     <= 1'b0;
      io_out_q    <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rbuf_q      <= rbuf_d;
      rdata_q     <= rdata_d;
      rsp_valid_q <= rsp_valid_d;
      ready_q     <= ready_d;
      cs_q        <= cs_d;
      oe_q        <= oe_d;
      we_q        <= we_d;
      a_q         <= a_d;
      io_oe_q     <= io_oe_d;
      io_out_q    <= io_out_d;
    end
  end

  assign bus.REQ_READY = ready_q;
  assign bus.RSP_VALID = rsp_valid_q;
  assign bus.RSP_RDATA = rdata_q;
  assign A             = a_q;
  assign CS            = cs_q;
  assign OE            = oe_q;
  assign WE            = we_q;
  assign IO            = io_oe_q ? io_out_q : 8'hzz;

endmodule

// File: doc/mem32k_word_ctrl.md
# mem32k_word_ctrl

Synchronous word-access controller placed directly upstream of the 32K x 8 asynchronous SRAM model (`MOD_MEM32K`). It accepts 32-bit read and write requests from the SHA-256 datapath over a valid/ready handshake. Each word is split into four big-endian byte cycles, and the block drives the SRAM's active-low CS/OE/WE strobes with fixed setup, strobe and hold phases. A single response-valid pulse completes every request; a write produces an ack, a read produces the assembled word.

## Interface
Parameters:
- STROBE_CYC, 2, width of the WE or OE-sample strobe in CLK cycles; legal range 1..15.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- REQ_VALID  input  1  request present.
- REQ_READY  output  1  controller idle and able to accept a request.
- REQ_WE  input  1  1 = write word, 0 = read word.
- REQ_ADDR  input  13  word address; byte address = {REQ_ADDR, 2'b00}.
- REQ_WDATA  input  32  write data; bits [31:24] go to byte offset 0.
- RSP_VALID  output  1  one-cycle pulse marking completion (read data or write ack).
- RSP_RDATA  output  32  read word; holds its value until the next read completes.
- A  output  15  SRAM address.
- IO  inout  8  SRAM data bus; driven only during write phases, Z otherwise.
- CS  output  1  SRAM chip select, active low.
- OE  output  1  SRAM output enable, active low.
- WE  output  1  SRAM write enable, active low.

Reset is asynchronous and active-high on RST; the block uses the single clock CLK.

## Operation
- Latching: on accept (REQ_VALID && REQ_READY at a rising edge), REQ_WE, REQ_ADDR and REQ_WDATA are captured. A 2-bit byte index starts at 0.
- Address: A = {addr, idx}. Byte idx maps to data bits [31-8*idx -: 8].
- States: IDLE, W_SETUP, W_PULSE, W_HOLD, R_SETUP, R_WAIT, TURN.
- IDLE
  - Outputs: CS=1, OE=1, WE=1, IO=Z, REQ_READY=1.
  - Transition: on accept, go to W_SETUP if REQ_WE, else R_SETUP.
- W_SETUP (1 cycle)
  - Outputs: CS=0, OE=1, WE=1; A valid; IO driven with the byte.
  - Transition: go to W_PULSE.
- W_PULSE (STROBE_CYC cycles)
  - Outputs: WE=0; A and IO stable.
  - Transition: go to W_HOLD.
- W_HOLD (1 cycle)
  - Outputs: WE=1; IO still driven.
  - Transition: if idx==3, go to TURN; else increment idx and go to W_SETUP.
- R_SETUP (1 cycle)
  - Outputs: CS=0, OE=0, WE=1; IO=Z; A valid.
  - Transition: go to R_WAIT.
- R_WAIT (STROBE_CYC cycles)
  - Action: IO is sampled into the byte slot of the read shift register at the rising edge that ends the last R_WAIT cycle.
  - Transition: if idx==3, go to TURN; else increment idx and go to R_SETUP. A changes while CS/OE stay low, which matches the SRAM's address-controlled read.
- TURN (1 cycle)
  - Outputs: CS=1, OE=1, WE=1, IO=Z, RSP_VALID=1.
  - For reads, RSP_RDATA is updated at entry to TURN.
  - Transition: go to IDLE. TURN guarantees bus turnaround before the next request.
- Invariants:
  - WE and OE are never both low.
  - IO is never driven while OE=0.
  - REQ_READY=1 only in IDLE. REQ_VALID in any other state is ignored and must be held by the requester.
- Reset values:
  - State = IDLE, CS=1, OE=1, WE=1, A=0, IO=Z.
  - REQ_READY=0 while RST is high, RSP_VALID=0, RSP_RDATA=0, idx=0.
- Reset mid-operation: strobes deassert and IO releases asynchronously, with no response pulse. A byte being written may be left corrupt; this is accepted behaviour.

## Timing
- Let S = STROBE_CYC, and let cycle 0 be the cycle in which the accept edge occurs.
- Write: each byte takes S+2 cycles. RSP_VALID is high in cycle 4(S+2)+1. With S=2, that is cycle 17.
- Read: each byte takes S+1 cycles. RSP_VALID is high in cycle 4(S+1)+1. With S=2, that is cycle 13.
- REQ_READY returns high the cycle after TURN. Back-to-back requests therefore have a minimum gap of 1 IDLE cycle.
- Outputs A, CS, OE, WE and the IO enable are registered. There is no combinational path from REQ_* to the SRAM pins.

## Test plan
- Reset: assert RST mid-write (during W_PULSE of byte 1) -> CS/OE/WE go to 1 immediately, IO=Z, REQ_READY stays 0 until release, and no RSP_VALID pulse occurs.
- Write 0xDEADBEEF at word 0x0010 -> buffer[0x40..0x43] = DE, AD, BE, EF; RSP_VALID at cycle 17 (S=2); WE low for exactly 2 cycles per byte.
- Preload buffer[0x44..0x47] = 01, 23, 45, 67, then read word 0x0011 -> RSP_RDATA = 0x01234567 with RSP_VALID at cycle 13; IO is never driven by the controller.
- Write 0xCAFEF00D then immediately read the same word (REQ_VALID held high) -> second request accepted 1 cycle after the first RSP_VALID; read returns 0xCAFEF00D.
- Top address: write 0x11223344 to word 0x1FFF -> A reaches 0x7FFF on byte 3 with no wrap into other addresses; read-back matches.
- Bench with STROBE_CYC=1 -> read latency 9 cycles, write latency 13 cycles; a checker confirms WE and OE are never both low and IO is not driven while OE=0.
